// File: rtl/multiplicador_seq_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// operand width, FSM state encoding and bit-counter sizing.
package multiplicador_seq_pkg;

    localparam int unsigned ALU_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter must hold the value WIDTH itself, not just WIDTH-1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    localparam int unsigned ALU_CNT_W = $clog2(ALU_WIDTH + 1);

endpackage

// File: rtl/mult_add_shift_step.sv
// One combinational shift-and-add step: conditionally add the multiplicand
// into the upper half of the accumulator, then shift right by one.
module mult_add_shift_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [2*WIDTH:0]  acc_i,
    input  logic [WIDTH-1:0]  mcand_i,
    input  logic              lsb_i,
    output logic [2*WIDTH:0]  acc_o
);

    logic [2*WIDTH:0] addend;
    logic [2*WIDTH:0] sum;

    // Sum cannot overflow 2*WIDTH+1 bits: the shifted accumulator stays below 2^(2*WIDTH).
    always_comb begin
        addend = '0;
        if (lsb_i) begin
            addend = {1'b0, mcand_i, WIDTH'(0)};
        end
        sum   = acc_i + addend;
        acc_o = sum >> 1;
    end

endmodule

// File: rtl/multiplicador_seq_top.sv
// Sequential unsigned multiplier: one multiplier bit per cycle, full
// 2*WIDTH product with overflow flag, start/busy/done handshake.
module multiplicador_seq_top
    import multiplicador_seq_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] data0_i,
    input  logic [WIDTH-1:0] data1_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic             overflow_o
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam int unsigned AW = 2 * WIDTH + 1;

    state_e           state_q,    state_d;
    logic [WIDTH-1:0] mcand_q,    mcand_d;
    logic [WIDTH-1:0] mplier_q,   mplier_d;
    logic [AW-1:0]    acc_q,      acc_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic [WIDTH-1:0] result_q,   result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             overflow_q, overflow_d;
    logic [AW-1:0]    acc_step;
    logic             accept;

    mult_add_shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .lsb_i   (mplier_q[0]),
        .acc_o   (acc_step)
    );

    // Next-state and output-register logic.
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        overflow_d  = overflow_q;
        accept      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                accept = start_i;
            end
            ST_RUN: begin
                acc_d    = acc_step;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d      = 1'b1;
                result_d    = acc_q[WIDTH-1:0];
                result_hi_d = acc_q[2*WIDTH-1:WIDTH];
                overflow_d  = |acc_q[2*WIDTH-1:WIDTH];
                state_d     = ST_IDLE;
                accept      = start_i;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A zero operand skips the iteration; the cleared accumulator is already the product.
        if (accept) begin
            mcand_d  = data0_i;
            mplier_d = data1_i;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH);
            state_d  = ((data0_i == '0) || (data1_i == '0)) ? ST_DONE : ST_RUN;
        end

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            overflow_q  <= overflow_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign result_o    = result_q;
    assign result_hi_o = result_hi_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_multiplicador_seq_top.sv
// Scoreboard bench for multiplicador_seq_top: stimulus pushes expected
// product and done cycle, a forked monitor pops and compares on done_o.
module tb_multiplicador_seq_top;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic [7:0] d0    = 8'h00;
    logic [7:0] d1    = 8'h00;
    logic       busy_o;
    logic       done_o;
    logic [7:0] result_o;
    logic [7:0] result_hi_o;
    logic       overflow_o;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [15:0] prod;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    multiplicador_seq_top #(.WIDTH(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .data0_i     (d0),
        .data1_i     (d1),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .result_o    (result_o),
        .result_hi_o (result_hi_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input string name, input logic [15:0] prod, input int lat);
        exp_t e;
        e.name = name;
        e.prod = prod;
        e.ovf  = (prod >= 16'h0100);
        e.cyc  = cyc + lat;
        sb.push_back(e);
    endtask

    // Present operands for one edge; expected done latency is 1 for a zero operand, else 9.
    task automatic issue(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] prod);
        start = 1'b1;
        d0    = a;
        d1    = b;
        tick();
        push(name, prod, ((a == 8'h00) || (b == 8'h00)) ? 1 : 9);
        start = 1'b0;
    endtask

    task automatic drain(output int busy_cnt);
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy_o) busy_cnt++;
            if (sb.size() == 0) break;
            tick();
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int   bc;
        exp_t e;

        fork
            forever begin
                @(negedge clk);
                if (!rst && done_o) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done: got result %0h at cycle %0d, expected no done",
                                 {result_hi_o, result_o}, cyc);
                    end else begin
                        e = sb.pop_front();
                        if ({result_hi_o, result_o} !== e.prod || overflow_o !== e.ovf || cyc != e.cyc) begin
                            errors++;
                            $display("FAIL %s: got prod=%0h ovf=%0b cyc=%0d expected prod=%0h ovf=%0b cyc=%0d",
                                     e.name, {result_hi_o, result_o}, overflow_o, cyc,
                                     e.prod, e.ovf, e.cyc);
                        end
                    end
                end
            end
        join_none

        tick();
        tick();
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        chk("reset_result", 32'({overflow_o, result_hi_o, result_o}), 32'd0);
        rst = 1'b0;
        tick();

        issue("13x11", 8'd13, 8'd11, 16'h008F);
        drain(bc);
        chk("busy_13x11", 32'(bc), 32'd8);

        issue("255x255", 8'hFF, 8'hFF, 16'hFE01);
        drain(bc);
        chk("busy_255x255", 32'(bc), 32'd8);

        issue("0x200", 8'd0, 8'd200, 16'h0000);
        drain(bc);
        chk("busy_0x200", 32'(bc), 32'd0);

        issue("200x0", 8'd200, 8'd0, 16'h0000);
        drain(bc);
        chk("busy_200x0", 32'(bc), 32'd0);

        // Second start lands mid-run and must be dropped.
        issue("3x5_ignore_7x7", 8'd3, 8'd5, 16'h000F);
        tick();
        tick();
        start = 1'b1;
        d0    = 8'd7;
        d1    = 8'd7;
        tick();
        start = 1'b0;
        drain(bc);
        repeat (12) tick();
        chk("hold_result_3x5", 32'(result_o), 32'h0F);

        // Reset mid-run: outputs clear immediately, the pending operation never completes.
        start = 1'b1;
        d0    = 8'd20;
        d1    = 8'd20;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_done", 32'(done_o), 32'd0);
        chk("midrst_result", 32'(result_o), 32'd0);
        chk("midrst_result_hi", 32'(result_hi_o), 32'd0);
        chk("midrst_overflow", 32'(overflow_o), 32'd0);
        tick();
        rst = 1'b0;
        bc  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy_o) bc++;
        end
        chk("midrst_no_busy", 32'(bc), 32'd0);

        // start held high across DONE: the second operation is accepted back-to-back.
        start = 1'b1;
        d0    = 8'd2;
        d1    = 8'd3;
        tick();
        push("b2b_2x3", 16'h0006, 9);
        d0 = 8'd4;
        d1 = 8'd4;
        repeat (8) tick();
        tick();
        push("b2b_4x4", 16'h0010, 9);
        start = 1'b0;
        drain(bc);

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            issue("sweep", a, b, 16'(a) * 16'(b));
            drain(bc);
        end

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
